// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;
    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;

    localparam int PS2_FIFO_DEPTH = 8;
    localparam int PTR_W          = $clog2(PS2_FIFO_DEPTH);
    typedef logic [PTR_W-1:0] ps2_ptr_t;
endpackage

// File: rtl/ps2_scan2ascii_rom.sv
// Registered Set-2 scan code to lowercase ASCII lookup; unmapped codes give 0x00.
module ps2_scan2ascii_rom (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] code,
    output logic [7:0] ascii
);
    logic [7:0] lut;

    always_comb begin
        lut = 8'h00;
        case (code)
            8'h1C: lut = "a"; 8'h32: lut = "b"; 8'h21: lut = "c"; 8'h23: lut = "d";
            8'h24: lut = "e"; 8'h2B: lut = "f"; 8'h34: lut = "g"; 8'h33: lut = "h";
            8'h43: lut = "i"; 8'h3B: lut = "j"; 8'h42: lut = "k"; 8'h4B: lut = "l";
            8'h3A: lut = "m"; 8'h31: lut = "n"; 8'h44: lut = "o"; 8'h4D: lut = "p";
            8'h15: lut = "q"; 8'h2D: lut = "r"; 8'h1B: lut = "s"; 8'h2C: lut = "t";
            8'h3C: lut = "u"; 8'h2A: lut = "v"; 8'h1D: lut = "w"; 8'h22: lut = "x";
            8'h35: lut = "y"; 8'h1A: lut = "z";
            8'h45: lut = "0"; 8'h16: lut = "1"; 8'h1E: lut = "2"; 8'h26: lut = "3";
            8'h25: lut = "4"; 8'h2E: lut = "5"; 8'h36: lut = "6"; 8'h3D: lut = "7";
            8'h3E: lut = "8"; 8'h46: lut = "9";
            8'h29: lut = 8'h20; 8'h5A: lut = 8'h0D; 8'h66: lut = 8'h08; 8'h0D: lut = 8'h09;
            8'h4E: lut = "-"; 8'h55: lut = "="; 8'h54: lut = "["; 8'h5B: lut = "]";
            8'h5D: lut = 8'h5C; 8'h4C: lut = ";"; 8'h52: lut = "'"; 8'h41: lut = ",";
            8'h49: lut = "."; 8'h4A: lut = "/"; 8'h0E: lut = 8'h60;
            default: lut = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) ascii <= 8'h00;
        else       ascii <= lut;
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: oversampled deframer feeding a scan-code FIFO.
// Define PS2_ASCII_LUT_EN to add the registered ascii output.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = PS2_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
`ifdef PS2_ASCII_LUT_EN
    output logic [7:0] ascii,
`endif
    output logic       overflow,
    output logic       parity_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    typedef logic [AW-1:0] ptr_t;

    logic [2:0]    clk_sync, dat_sync;
    logic [3:0]    bit_cnt;
    logic [9:0]    sreg;
    logic [IW-1:0] idle_cnt;
    logic [10:0]   frame;
    logic          fall, bit_in, frame_end, frame_ok, timeout;
    logic [7:0]    mem [FIFO_DEPTH];
    ptr_t          w_ptr, r_ptr;
    logic          wr_req, full, pop;

    // Synchronisers idle high so reset never fakes a falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    assign fall      = clk_sync[2] & ~clk_sync[1];
    assign bit_in    = dat_sync[1];
    assign frame_end = fall && (bit_cnt == 4'(PS2_FRAME_BITS - 1));
    assign frame     = {bit_in, sreg};
    assign frame_ok  = ~frame[0] & frame[10] & (^frame[9:1]);
    assign timeout   = (bit_cnt != 4'd0) && (idle_cnt == IW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt    <= 4'd0;
            sreg       <= '0;
            idle_cnt   <= '0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= frame_end & ~frame_ok;
            if (fall) begin
                idle_cnt <= '0;
                sreg     <= {bit_in, sreg[9:1]};
                bit_cnt  <= frame_end ? 4'd0 : bit_cnt + 4'd1;
            end else if (timeout) begin
                bit_cnt  <= 4'd0;
                idle_cnt <= '0;
            end else if (idle_cnt != IW'(TIMEOUT_CYCLES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Full is judged on the pre-pop pointers, so a write racing a pop on a full FIFO drops.
    assign wr_req = frame_end & frame_ok;
    assign full   = ptr_t'(w_ptr + 1'b1) == r_ptr;
    assign ready  = w_ptr != r_ptr;
    assign pop    = ~nextdata_n & ready;
    assign data   = mem[r_ptr];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_req && !full) w_ptr <= w_ptr + 1'b1;
            if (pop)             r_ptr <= r_ptr + 1'b1;
            if (wr_req && full)  overflow <= 1'b1;
            else if (pop)        overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_req && !full) mem[w_ptr] <= frame[8:1];
    end

`ifdef PS2_ASCII_LUT_EN
    ps2_scan2ascii_rom u_rom (
        .clk   (clk),
        .clrn  (clrn),
        .code  (data),
        .ascii (ascii)
    );
`endif
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: table of frames plus reset/overflow/timeout sequences.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 400;
    localparam int HP    = 20;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk, ps2_data, nextdata_n;
    logic [7:0] data;
    logic       ready, overflow, parity_err;
`ifdef PS2_ASCII_LUT_EN
    logic [7:0] ascii;
`endif

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
`ifdef PS2_ASCII_LUT_EN
        .ascii      (ascii),
`endif
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int perr_cnt = 0;
    logic [7:0] exp_q[$];
    bit model_ovf = 1'b0;

    always @(posedge clk) if (parity_err) perr_cnt <= perr_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One PS/2 bit: data set while the line clock is high, then a low phase.
    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) ps2_bit(1'b0);
        @(negedge clk) ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad);
        logic [10:0] f;
        bit was_rdy;
        f = {1'b1, (~^code) ^ bad, code, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        @(negedge clk) ps2_data = f[10];
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b0;
        was_rdy = exp_q.size() != 0;
        if (!bad) begin
            if (exp_q.size() < DEPTH - 1) exp_q.push_back(code);
            else model_ovf = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("ready_before_write", ready, was_rdy);
        chk("parity_err_early", parity_err, 0);
        @(negedge clk);
        chk("ready_after_write", ready, exp_q.size() != 0);
        chk("parity_err_pulse", parity_err, bad);
        if (!was_rdy && !bad) chk("data_head", data, code);
        repeat (HP - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    task automatic pop_chk(input string nm);
        logic [7:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({nm, "_empty"}, ready, 0);
            return;
        end
        e = exp_q.pop_front();
        chk({nm, "_data"}, data, e);
        nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
        model_ovf = 1'b0;
        chk({nm, "_ready"}, ready, exp_q.size() != 0);
        chk({nm, "_ovf"}, overflow, model_ovf);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic [7:0] asc;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tbl[0] = '{8'h1C, 1'b0, 8'h61};
        tbl[1] = '{8'h1C, 1'b1, 8'h00};
        tbl[2] = '{8'h29, 1'b0, 8'h20};
        tbl[3] = '{8'h5A, 1'b0, 8'h0D};
        tbl[4] = '{8'h66, 1'b1, 8'h00};
        tbl[5] = '{8'h66, 1'b0, 8'h08};
        tbl[6] = '{8'h45, 1'b0, 8'h30};
        tbl[7] = '{8'hFF, 1'b0, 8'h00};

        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_parity_err", parity_err, 0);
        clrn = 1'b1;

        // A pop strobe on an empty FIFO must be ignored.
        @(negedge clk) nextdata_n = 1'b0;
        repeat (2) @(negedge clk);
        nextdata_n = 1'b1;
        chk("empty_pop_ready", ready, 0);

        foreach (tbl[k]) begin
            p0 = perr_cnt;
            send_frame(tbl[k].code, tbl[k].bad);
            chk("perr_count", perr_cnt - p0, tbl[k].bad);
`ifdef PS2_ASCII_LUT_EN
            if (!tbl[k].bad) chk("ascii_lut", ascii, tbl[k].asc);
`endif
            pop_chk("tbl_pop");
        end

        send_frame(PS2_BREAK, 1'b0);
        send_frame(8'h1C, 1'b0);
        pop_chk("brk_pop0");
        pop_chk("brk_pop1");

        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_model", model_ovf, 1);
        while (exp_q.size() != 0) pop_chk("ovf_drain");

        send_bits(4);
        repeat (TMO + 20) @(negedge clk);
        send_frame(8'h29, 1'b0);
        pop_chk("tmo_pop");
        pop_chk("tmo_after");

        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h30 + i), 1'b0);
        chk("pre_rst_ovf", overflow, 1);
        send_bits(5);
        @(negedge clk) clrn = 1'b0;
        #1;
        chk("async_rst_ready", ready, 0);
        chk("async_rst_ovf", overflow, 0);
        exp_q.delete();
        model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        send_frame(8'h29, 1'b0);
`ifdef PS2_ASCII_LUT_EN
        chk("post_rst_ascii", ascii, 8'h20);
`endif
        pop_chk("post_rst_pop");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 device-to-host receiver. Oversamples the keyboard's PS2 clock/data lines in the system clock domain and deframes 11-bit frames.
- Valid scan-code bytes go into a small FIFO that the keyboard handler drains with a one-cycle pop strobe.
- Sits between the board PS2 pins and the scan-code/modifier state machine.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 50000, number of clk cycles without a PS2 clock falling edge, mid-frame, before the partial frame is discarded.

Ports:
- clk  input  1  system clock.
- clrn  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS2 clock line; receive-only, never driven.
- ps2_data  input  1  raw PS2 data line; receive-only, never driven.
- data  output  8  byte at FIFO head; meaningful only while ready=1.
- ready  output  1  FIFO non-empty.
- nextdata_n  input  1  active-low pop strobe.
- overflow  output  1  sticky: a valid byte was dropped because the FIFO was full.
- parity_err  output  1  one-cycle pulse: a frame was rejected.
- ascii  output  8  optional; see Optional Feature.

Behaviour:
- Reset (clrn=0, asynchronous):
  - read/write pointers 0, bit count 0, overflow 0, parity_err 0.
  - ps2_clk/ps2_data synchroniser flops preset to 1 (idle).
  - Consequently ready=0.
- Synchronisation:
  - ps2_clk passes through a 3-flop chain; ps2_data through a 3-flop chain of the same depth.
  - Falling edge = stage2==1 && stage1==0. The data bit is taken from the matching ps2_data stage on that cycle.
- Deframing:
  - 4-bit counter 0..10 counts falling edges; bits go into a 10-bit shift register.
  - Bit order: start (must be 0), D0..D7 LSB-first, odd parity, stop (must be 1).
  - On the 11th edge the frame is checked: start==0, stop==1, and XOR of D0..D7 plus parity == 1.
  - Good frame: byte written to FIFO[w_ptr] and w_ptr incremented in that same clk cycle. ready rises on the next cycle.
  - Bad frame: byte discarded and parity_err pulses for one cycle.
  - In both cases the counter returns to 0.
- Timeout:
  - Idle counter resets on every falling edge.
  - If the bit count is non-zero and the idle counter reaches TIMEOUT_CYCLES, the bit count resets to 0 and the partial byte is dropped silently.
- FIFO:
  - ready = (w_ptr != r_ptr). data = FIFO[r_ptr], combinational from storage.
  - Pop: at a clk edge where nextdata_n==0 and ready==1, r_ptr increments.
  - nextdata_n==0 while empty is ignored.
  - A consumer holding nextdata_n low for N cycles pops N bytes. The handler pulses it for exactly one cycle.
  - Full = (w_ptr+1)==r_ptr modulo depth, so usable capacity is FIFO_DEPTH-1.
  - Write while full: byte dropped, overflow set to 1.
  - overflow clears on the next successful pop.
  - Simultaneous pop and write in one cycle: both take effect. Full is evaluated before the pop, so a write coinciding with a pop on a full FIFO is still dropped.
- Pointer arithmetic: log2(FIFO_DEPTH) bits, wraps naturally.

Optional Feature:
- Macro: PS2_ASCII_LUT_EN.
- When defined:
  - ascii = registered ROM lookup of data; one clk cycle latency, indexed by the current head byte.
  - Map Set-2 codes to lowercase ASCII: letters a-z, digits 0-9, space 0x29->0x20, enter 0x5A->0x0D, backspace 0x66->0x08, and common punctuation.
  - Unmapped codes give 0x00.
  - Implemented as a sub-module.
- When undefined: the ascii port is absent.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_FRAME_BITS=11, PS2_BREAK=8'hF0, PS2_EXT=8'hE0;
  - localparam PTR_W derivation;
  - a typedef for the FIFO pointer.
- One natural sub-module: ps2_scan2ascii_rom, the ascii ROM under PS2_ASCII_LUT_EN. The synchroniser and FIFO stay inline.

Test Plan:
- Frame for 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) at ~12 kHz -> ready=1 one cycle after the 11th falling edge, data=0x1C, parity_err stays 0.
- Sequence F0, 1C then pop strobes -> data reads 0xF0 then 0x1C. ready drops after the second single-cycle nextdata_n pulse.
- 0x1C frame with parity bit 1 -> no write, ready stays 0, parity_err pulses once.
- Send 8 frames with no pops (depth 8) -> 7 stored, overflow=1; the first pop returns the first byte and clears overflow.
- 4 bits of a frame, then idle for TIMEOUT_CYCLES+1, then a full 0x29 frame -> only 0x29 is received.
- clrn low mid-frame and with bytes queued -> ready=0 and overflow=0 immediately; the next full frame is received correctly. With PS2_ASCII_LUT_EN, 0x29 gives ascii=0x20 one cycle after data is valid.
